instr_decode_queue: RTL and testbench
=====================================

# instr_decode_queue

Parametrised, registered successor to the combinational instruction-control decoder. Accepts fetched instructions over a valid/ready handshake, decodes opcode class into datapath control at enqueue time, and buffers decoded entries in a DEPTH-entry FIFO feeding the execute stage. Adds flush on redirect, illegal-instruction flagging, and FENCE ordering against outstanding memory traffic. Sits between fetch and execute.

## Interface
- DEPTH, 4, number of buffered entries; power of two, ≥2
- XLEN, 32, width of the PC carried alongside each instruction
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- flush  in  1  discard all buffered entries (branch/jump redirect)
- mem_busy  in  1  high while any memory access is outstanding downstream
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  queue accepts this cycle
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction address
- out_valid  out  1  head entry presented to execute
- out_ready  in  1  execute consumes head
- out_instr  out  32  head instruction
- out_pc  out  XLEN  head address
- should_read_mem, should_write_mem, should_write_reg, should_branch, should_jump  out  1 each  head control
- alu_a_src, alu_b_src  out  3 each  head ALU operand selects
- illegal  out  1  head instruction not decodable
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Decode on enqueue from instr[6:2] (read_mem, write_mem, write_reg, branch, jump, a_src, b_src):
  - 0x00 load: 1,0,1,0,0,7,3
  - 0x03 fence: all 0, a/b 0; marked fence
  - 0x04 op-imm: 0,0,1,0,0,7,3
  - 0x05 auipc: 0,0,1,0,0,1,4
  - 0x08 store: 0,1,0,0,0,7,3
  - 0x0c op: 0,0,1,0,0,7,7
  - 0x0d lui: 0,0,1,0,0,0,4
  - 0x18 branch: 0,0,0,1,0,1,5
  - 0x19 jalr: 0,0,1,0,1,1,3
  - 0x1b jal: 0,0,1,0,1,1,6
  - any other opcode, or instr[1:0]≠2'b11: all controls 0, illegal=1
- Entry stores instr, pc, decoded controls, illegal, fence bit; circular FIFO, read/write pointers wrap modulo DEPTH.
- Enqueue when in_valid & in_ready; dequeue when out_valid & out_ready.
- in_ready = (count < DEPTH) & ~flush & ~reset. No pass-through when full, even if dequeuing the same cycle.
- Simultaneous enqueue+dequeue: count unchanged, both pointers advance.
- FSM, two states:
  - RUN: out_valid = (count≠0) & ~head_fence. If head is fence → FENCE_WAIT next cycle.
  - FENCE_WAIT: out_valid = ~mem_busy. On dequeue → RUN.
- Control outputs and illegal forced 0 whenever out_valid=0; out_instr/out_pc always show the head slot.
- flush: next cycle count=0, pointers=0, state=RUN; same-cycle in_valid ignored; a same-cycle dequeue still completes (execute sees it), nothing else survives.
- Flush takes priority over enqueue; reset takes priority over everything.

## Timing
- Reset: count=0, pointers=0, state RUN, out_valid=0, all controls/illegal 0, in_ready=0 while reset high, 1 the cycle after.
- Latency: instruction accepted in cycle N is earliest out_valid in N+1; no combinational in→out path.
- Full throughput: one enqueue and one dequeue per cycle sustained.
- Fence at head: at least one cycle of out_valid=0 (RUN→FENCE_WAIT transition), then held until mem_busy=0.
- mem_busy rising while fence presented but not consumed: out_valid drops; out_valid may fall without a handshake only in FENCE_WAIT.
- Otherwise out_valid, once high, stays high with stable outputs until consumed or flush.

## Test plan
- Reset, then enqueue 0x00012083 (lw) at pc 0x100 -> next cycle out_valid=1, read_mem=1, write_reg=1, a_src=7, b_src=3, out_pc=0x100.
- Enqueue DEPTH=4 back-to-back with out_ready=0 -> count=4, in_ready=0; 5th held; then out_ready=1 -> drained in order, count 4→0, one per cycle.
- Enqueue 0x0FF0000F (fence) with mem_busy=1 for 5 cycles -> out_valid=0 throughout; mem_busy=0 -> out_valid=1, all controls 0; consume -> state RUN.
- Enqueue 0x00000000 and 0x0000007F -> both present illegal=1, all controls 0.
- Fill 3 entries, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, flushed-cycle instruction absent.
- Continuous enqueue/dequeue of 0x002081B3 (add) and 0x008000EF (jal) for 20 cycles -> count constant, jal shows jump=1, a_src=1, b_src=6.

Source files
------------

// File: rtl/instr_decode_queue_if.sv
// rtl/instr_decode_queue_if.sv - fetch-in / execute-out handshake bundle for the decode queue
interface instr_decode_queue_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic            should_read_mem;
    logic            should_write_mem;
    logic            should_write_reg;
    logic            should_branch;
    logic            should_jump;
    logic [2:0]      alu_a_src;
    logic [2:0]      alu_b_src;
    logic            illegal;

    // Fetch/execute side: offers instructions, consumes decoded entries
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc,
        input  should_read_mem, should_write_mem, should_write_reg,
        input  should_branch, should_jump, alu_a_src, alu_b_src, illegal
    );

    // Queue side
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc,
        output should_read_mem, should_write_mem, should_write_reg,
        output should_branch, should_jump, alu_a_src, alu_b_src, illegal
    );
endinterface

// File: rtl/instr_decode_queue.sv
// rtl/instr_decode_queue.sv - decode-at-enqueue instruction FIFO with flush and fence ordering
module instr_decode_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     mem_busy,
    instr_decode_queue_if.slave      bus,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic       rd_mem;
        logic       wr_mem;
        logic       wr_reg;
        logic       branch;
        logic       jump;
        logic [2:0] a_src;
        logic [2:0] b_src;
        logic       illegal;
        logic       fence;
    } ctrl_t;

    typedef enum logic {S_RUN, S_FENCE_WAIT} state_t;

    // Opcode class -> datapath controls; anything unrecognised is flagged illegal with all controls low
    function automatic ctrl_t decode(input logic [31:0] instr);
        ctrl_t c;
        c = '0;
        if (instr[1:0] != 2'b11) begin
            c.illegal = 1'b1;
        end else begin
            case (instr[6:2])
                5'h00: begin c.rd_mem = 1'b1; c.wr_reg = 1'b1; c.a_src = 3'd7; c.b_src = 3'd3; end
                5'h03: c.fence = 1'b1;
                5'h04: begin c.wr_reg = 1'b1; c.a_src = 3'd7; c.b_src = 3'd3; end
                5'h05: begin c.wr_reg = 1'b1; c.a_src = 3'd1; c.b_src = 3'd4; end
                5'h08: begin c.wr_mem = 1'b1; c.a_src = 3'd7; c.b_src = 3'd3; end
                5'h0c: begin c.wr_reg = 1'b1; c.a_src = 3'd7; c.b_src = 3'd7; end
                5'h0d: begin c.wr_reg = 1'b1; c.a_src = 3'd0; c.b_src = 3'd4; end
                5'h18: begin c.branch = 1'b1; c.a_src = 3'd1; c.b_src = 3'd5; end
                5'h19: begin c.wr_reg = 1'b1; c.jump = 1'b1; c.a_src = 3'd1; c.b_src = 3'd3; end
                5'h1b: begin c.wr_reg = 1'b1; c.jump = 1'b1; c.a_src = 3'd1; c.b_src = 3'd6; end
                default: c.illegal = 1'b1;
            endcase
        end
        return c;
    endfunction

    logic [31:0]     instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];
    ctrl_t           ctrl_mem  [DEPTH];

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;

    ctrl_t head;
    logic  enq;
    logic  deq;
    logic  out_valid;

    // Handshakes, head presentation and next-state for pointers, occupancy and fence FSM
    always_comb begin
        head         = ctrl_mem[rd_ptr_q];
        bus.in_ready = (count_q < CW'(DEPTH)) & ~flush & ~reset;

        out_valid = 1'b0;
        case (state_q)
            S_RUN:        out_valid = (count_q != '0) & ~head.fence;
            S_FENCE_WAIT: out_valid = ~mem_busy;
            default:      out_valid = 1'b0;
        endcase

        enq = bus.in_valid & bus.in_ready;
        deq = out_valid & bus.out_ready;

        state_d  = state_q;
        count_d  = count_q + CW'(enq) - CW'(deq);
        rd_ptr_d = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;

        case (state_q)
            S_RUN:        if ((count_q != '0) && head.fence) state_d = S_FENCE_WAIT;
            S_FENCE_WAIT: if (deq) state_d = S_RUN;
            default:      state_d = S_RUN;
        endcase

        // A redirect empties the queue; a same-cycle dequeue has already been seen by execute
        if (flush) begin
            state_d  = S_RUN;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    // Control state and fence FSM register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_RUN;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Entry storage, written with the decoded controls on enqueue
    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem[wr_ptr_q] <= bus.in_instr;
            pc_mem[wr_ptr_q]    <= bus.in_pc;
            ctrl_mem[wr_ptr_q]  <= decode(bus.in_instr);
        end
    end

    // Head presentation; controls are only asserted alongside out_valid
    always_comb begin
        bus.out_valid        = out_valid;
        bus.out_instr        = instr_mem[rd_ptr_q];
        bus.out_pc           = pc_mem[rd_ptr_q];
        bus.should_read_mem  = out_valid & head.rd_mem;
        bus.should_write_mem = out_valid & head.wr_mem;
        bus.should_write_reg = out_valid & head.wr_reg;
        bus.should_branch    = out_valid & head.branch;
        bus.should_jump      = out_valid & head.jump;
        bus.alu_a_src        = out_valid ? head.a_src : 3'd0;
        bus.alu_b_src        = out_valid ? head.b_src : 3'd0;
        bus.illegal          = out_valid & head.illegal;
        count                = count_q;
    end
endmodule

// File: tb/tb_instr_decode_queue.sv
// tb/tb_instr_decode_queue.sv - self-checking bench for instr_decode_queue
module tb_instr_decode_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    localparam logic [31:0] I_LW    = 32'h0001_2083;
    localparam logic [31:0] I_FENCE = 32'h0FF0_000F;
    localparam logic [31:0] I_ADD   = 32'h0020_81B3;
    localparam logic [31:0] I_JAL   = 32'h0080_00EF;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic mem_busy;
    logic [$clog2(DEPTH):0] count;

    instr_decode_queue_if #(.XLEN(XLEN)) bus_if ();

    instr_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .mem_busy (mem_busy),
        .bus      (bus_if),
        .count    (count)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference: opcode table as {rd,wr,wreg,br,jmp,a[2:0],b[2:0]}, plus which opcodes are defined
    logic [10:0] dec_tab [32];
    bit          op_ok   [32];

    // Reference queue contents and how many cycles a fence has already sat at the head
    logic [31:0] mq_instr [$];
    logic [31:0] mq_pc    [$];
    int          fence_age = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [11:0] dut_ctrl();
        return {bus_if.should_read_mem, bus_if.should_write_mem, bus_if.should_write_reg,
                bus_if.should_branch, bus_if.should_jump, bus_if.alu_a_src, bus_if.alu_b_src,
                bus_if.illegal};
    endfunction

    function automatic logic [11:0] exp_ctrl(input logic [31:0] ins);
        logic [4:0] op;
        op = ins[6:2];
        if (ins[1:0] != 2'b11 || !op_ok[op]) return 12'h001;
        return {dec_tab[op], 1'b0};
    endfunction

    function automatic bit is_fence(input logic [31:0] ins);
        return ins[1:0] == 2'b11 && ins[6:2] == 5'h03;
    endfunction

    // One clock cycle: drive, compare outputs against the reference, advance the reference
    task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl, input logic mb);
        bit exp_rdy, exp_ov, enq, deq, head_fence;
        bus_if.in_valid  = iv;
        bus_if.in_instr  = ins;
        bus_if.in_pc     = pc;
        bus_if.out_ready = ordy;
        flush            = fl;
        mem_busy         = mb;
        #1;
        head_fence = (mq_instr.size() != 0) && is_fence(mq_instr[0]);
        exp_rdy    = (mq_instr.size() < DEPTH) && !fl;
        if (mq_instr.size() == 0) exp_ov = 1'b0;
        else if (!head_fence)     exp_ov = 1'b1;
        else                      exp_ov = (fence_age >= 1) && !mb;

        chk("in_ready", 64'(bus_if.in_ready), 64'(exp_rdy));
        chk("count", 64'(count), 64'(mq_instr.size()));
        chk("out_valid", 64'(bus_if.out_valid), 64'(exp_ov));
        if (exp_ov) begin
            chk("out_instr", 64'(bus_if.out_instr), 64'(mq_instr[0]));
            chk("out_pc", 64'(bus_if.out_pc), 64'(mq_pc[0]));
            chk("ctrl", 64'(dut_ctrl()), 64'(exp_ctrl(mq_instr[0])));
        end else begin
            chk("ctrl_idle", 64'(dut_ctrl()), 64'd0);
        end

        enq = iv && exp_rdy;
        deq = exp_ov && ordy;
        if (fl) begin
            mq_instr.delete();
            mq_pc.delete();
            fence_age = 0;
        end else begin
            if (head_fence && !deq) fence_age++;
            else fence_age = 0;
            if (deq) begin
                void'(mq_instr.pop_front());
                void'(mq_pc.pop_front());
            end
            if (enq) begin
                mq_instr.push_back(ins);
                mq_pc.push_back(pc);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Quiet the inputs and let outputs settle for a literal check
    task automatic peek(input logic mb);
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        flush            = 1'b0;
        mem_busy         = mb;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] legal_ops [10];
        legal_ops = '{32'h00, 32'h03, 32'h04, 32'h05, 32'h08, 32'h0c, 32'h0d, 32'h18, 32'h19, 32'h1b};
        for (int i = 0; i < 32; i++) begin
            dec_tab[i] = '0;
            op_ok[i]   = 1'b0;
        end
        dec_tab[5'h00] = {5'b10100, 3'd7, 3'd3}; op_ok[5'h00] = 1'b1;
        dec_tab[5'h03] = {5'b00000, 3'd0, 3'd0}; op_ok[5'h03] = 1'b1;
        dec_tab[5'h04] = {5'b00100, 3'd7, 3'd3}; op_ok[5'h04] = 1'b1;
        dec_tab[5'h05] = {5'b00100, 3'd1, 3'd4}; op_ok[5'h05] = 1'b1;
        dec_tab[5'h08] = {5'b01000, 3'd7, 3'd3}; op_ok[5'h08] = 1'b1;
        dec_tab[5'h0c] = {5'b00100, 3'd7, 3'd7}; op_ok[5'h0c] = 1'b1;
        dec_tab[5'h0d] = {5'b00100, 3'd0, 3'd4}; op_ok[5'h0d] = 1'b1;
        dec_tab[5'h18] = {5'b00010, 3'd1, 3'd5}; op_ok[5'h18] = 1'b1;
        dec_tab[5'h19] = {5'b00101, 3'd1, 3'd3}; op_ok[5'h19] = 1'b1;
        dec_tab[5'h1b] = {5'b00101, 3'd1, 3'd6}; op_ok[5'h1b] = 1'b1;

        // Reset
        reset = 1'b1; flush = 1'b0; mem_busy = 1'b0;
        bus_if.in_valid = 1'b0; bus_if.in_instr = '0; bus_if.in_pc = '0; bus_if.out_ready = 1'b0;
        @(negedge clk); #1;
        chk("rst_in_ready", 64'(bus_if.in_ready), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
        chk("rst_ctrl", 64'(dut_ctrl()), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(bus_if.in_ready), 64'd1);
        chk("post_rst_count", 64'(count), 64'd0);

        // Single load
        cycle(1'b1, I_LW, 32'h100, 1'b0, 1'b0, 1'b0);
        peek(1'b0);
        chk("lw_valid", 64'(bus_if.out_valid), 64'd1);
        chk("lw_ctrl", 64'(dut_ctrl()), 64'({5'b10100, 3'd7, 3'd3, 1'b0}));
        chk("lw_pc", 64'(bus_if.out_pc), 64'h100);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Fill to DEPTH, offer a fifth while full, then drain in order
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 32'h0000_0013 | (32'(i) << 20), 32'h200 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        peek(1'b0);
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(bus_if.in_ready), 64'd0);
        cycle(1'b1, 32'h0550_0013, 32'h210, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < DEPTH; j++) begin
            peek(1'b0);
            chk("drain_count", 64'(count), 64'(DEPTH - j));
            chk("drain_pc", 64'(bus_if.out_pc), 64'(32'h200 + 32'(4 * j)));
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        end
        peek(1'b0);
        chk("drained_count", 64'(count), 64'd0);

        // Fence held behind outstanding memory traffic
        cycle(1'b1, I_FENCE, 32'h300, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            peek(1'b1);
            chk("fence_hold", 64'(bus_if.out_valid), 64'd0);
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        end
        peek(1'b0);
        chk("fence_release", 64'(bus_if.out_valid), 64'd1);
        chk("fence_ctrl", 64'(dut_ctrl()), 64'd0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, I_LW, 32'h304, 1'b0, 1'b0, 1'b0);
        peek(1'b0);
        chk("after_fence_run", 64'(bus_if.out_valid), 64'd1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Illegal encodings
        cycle(1'b1, 32'h0000_0000, 32'h400, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_007F, 32'h404, 1'b0, 1'b0, 1'b0);
        peek(1'b0);
        chk("ill0_ctrl", 64'(dut_ctrl()), 64'h001);
        chk("ill0_pc", 64'(bus_if.out_pc), 64'h400);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        peek(1'b0);
        chk("ill1_ctrl", 64'(dut_ctrl()), 64'h001);
        chk("ill1_pc", 64'(bus_if.out_pc), 64'h404);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush with a same-cycle offer
        for (int i = 0; i < 3; i++)
            cycle(1'b1, I_ADD, 32'h500 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h1234_5013, 32'h50C, 1'b0, 1'b1, 1'b0);
        peek(1'b0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(bus_if.out_valid), 64'd0);
        cycle(1'b1, I_LW, 32'h600, 1'b0, 1'b0, 1'b0);
        peek(1'b0);
        chk("post_flush_pc", 64'(bus_if.out_pc), 64'h600);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Sustained enqueue+dequeue
        cycle(1'b1, I_ADD, 32'h6FC, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, (i % 2 == 1) ? I_JAL : I_ADD, 32'h700 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
            peek(1'b0);
            chk("stream_count", 64'(count), 64'd1);
            if (i % 2 == 1) chk("stream_jal", 64'(dut_ctrl()), 64'({5'b00101, 3'd1, 3'd6, 1'b0}));
            else            chk("stream_add", 64'(dut_ctrl()), 64'({5'b00100, 3'd7, 3'd7, 1'b0}));
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Randomised traffic
        for (int n = 0; n < 800; n++) begin
            logic [31:0] ins;
            int          r;
            r = $urandom_range(0, 9);
            if (r == 0)      ins = I_FENCE;
            else if (r == 1) ins = $urandom;
            else if (r < 6)  ins = {$urandom_range(0, 32'h1FF_FFFF) & 25'h1FF_FFFF,
                                    legal_ops[$urandom_range(0, 9)][4:0], 2'b11};
            else             ins = {$urandom_range(0, 32'h1FF_FFFF) & 25'h1FF_FFFF,
                                    5'($urandom_range(0, 31)), 2'b11};
            cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, ins, $urandom,
                  ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
